// File: rtl/issue_controller_pkg.sv
// Shared encodings for the decode/issue boundary and the issue controller state type.
package issue_controller_pkg;

    localparam logic [1:0] WB_NONE  = 2'd0;
    localparam logic [1:0] WB_RD    = 2'd1;
    localparam logic [1:0] WB_ADDR  = 2'd2;

    localparam logic [1:0] JMP_SEQ  = 2'd0;
    localparam logic [1:0] JMP_JUMP = 2'd1;
    localparam logic [1:0] JMP_BR   = 2'd2;

    localparam logic [1:0] MEM_NONE  = 2'd0;
    localparam logic [1:0] MEM_LOAD  = 2'd1;
    localparam logic [1:0] MEM_STORE = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_JWAIT = 2'd1,
        ST_MWAIT = 2'd2,
        ST_HALT  = 2'd3
    } issue_state_e;

    function automatic logic [31:0] reg_bit(input logic [4:0] r);
        logic [31:0] m;
        m    = '0;
        m[r] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/issue_controller_scoreboard.sv
// Pending-writeback register scoreboard: one busy bit per architectural register.
// x0 is never marked busy, so it can never produce a hazard.
import issue_controller_pkg::*;

module issue_controller_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_en,
    input  logic [4:0]  set_rd,
    input  logic        clr_en,
    input  logic [4:0]  clr_rd,
    input  logic [31:0] check_mask,
    output logic [31:0] busy_mask,
    output logic        hazard,
    output logic        clr_hit
);

    logic [31:0] busy_q;
    logic [31:0] busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Clear is applied before set so a coinciding set of the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d = busy_d & ~reg_bit(clr_rd);
        end
        if (set_en) begin
            busy_d = busy_d | reg_bit(set_rd);
        end
        busy_d[0] = 1'b0;
    end

    assign busy_mask = busy_q;
    assign hazard    = |(check_mask & busy_q);
    assign clr_hit   = clr_en && (clr_rd != 5'd0) && busy_q[clr_rd];

endmodule

// File: rtl/issue_controller.sv
// Issue sequencer between decode and execute: scoreboard hazard stall, inflight
// limit, serialisation of control-flow and memory ops, and sticky halt on fault.
import issue_controller_pkg::*;

module issue_controller #(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [31:0]      dec_active_reg,
    input  logic [4:0]       dec_rd,
    input  logic [1:0]       dec_wb_op,
    input  logic [1:0]       dec_jmp_op,
    input  logic [1:0]       dec_mem_op,
    input  logic             dec_fault,
    output logic             dec_ready,
    output logic             issue_valid,
    input  logic             issue_ready,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             jmp_resolved,
    input  logic             mem_done,
    output logic [31:0]      busy_mask,
    output logic [CNT_W-1:0] inflight,
    output logic             halted,
    output logic [1:0]       dbg_state
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    issue_state_e     state_q;
    issue_state_e     state_d;
    logic [CNT_W-1:0] inflight_q;
    logic             hazard;
    logic             clr_hit;
    logic             fire;
    logic             set_en;

    issue_controller_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en     (set_en),
        .set_rd     (dec_rd),
        .clr_en     (wb_valid),
        .clr_rd     (wb_rd),
        .check_mask (dec_active_reg),
        .busy_mask  (busy_mask),
        .hazard     (hazard),
        .clr_hit    (clr_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (dec_valid && dec_fault) begin
                    state_d = ST_HALT;
                end else if (fire) begin
                    if (dec_jmp_op != JMP_SEQ) begin
                        state_d = ST_JWAIT;
                    end else if (dec_mem_op != MEM_NONE) begin
                        state_d = ST_MWAIT;
                    end
                end
            end
            ST_JWAIT: if (jmp_resolved) state_d = ST_RUN;
            ST_MWAIT: if (mem_done) state_d = ST_RUN;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RUN;
        endcase
    end

    // Handshake: issue_valid depends only on current inputs and registered state and
    // never on issue_ready; an instruction transfers on issue_valid && issue_ready,
    // and dec_ready mirrors that transfer so the decoder holds its inputs until then.
    always_comb begin
        issue_valid = (state_q == ST_RUN) && dec_valid && !dec_fault && !hazard
                      && (inflight_q < MAX_CNT)
                      && !((dec_wb_op != WB_NONE) && (inflight_q == MAX_CNT));
        fire        = issue_valid && issue_ready;
        dec_ready   = fire;
        set_en      = fire && (dec_wb_op != WB_NONE) && (dec_rd != 5'd0);
        halted      = (state_q == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
        end else begin
            case ({set_en, clr_hit})
                2'b10:   inflight_q <= inflight_q + CNT_W'(1);
                2'b01:   inflight_q <= inflight_q - CNT_W'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    assign inflight  = inflight_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_issue_controller.sv
// Bench for issue_controller: directed hazard/serialisation scenarios followed by
// randomized traffic, checked cycle by cycle against a behavioural model.
module tb_issue_controller;

    localparam int MAXI = 4;
    localparam int W    = 39;
    localparam int M_RUN = 0, M_JWAIT = 1, M_MWAIT = 2, M_HALT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dec_valid = 1'b0;
    logic [31:0] dec_active_reg = '0;
    logic [4:0]  dec_rd = '0;
    logic [1:0]  dec_wb_op = '0;
    logic [1:0]  dec_jmp_op = '0;
    logic [1:0]  dec_mem_op = '0;
    logic        dec_fault = 1'b0;
    logic        dec_ready;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        jmp_resolved = 1'b0;
    logic        mem_done = 1'b0;
    logic [31:0] busy_mask;
    logic [3:0]  inflight;
    logic        halted;
    logic [1:0]  dbg_state;

    issue_controller #(.MAX_INFLIGHT(MAXI), .CNT_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .dec_valid      (dec_valid),
        .dec_active_reg (dec_active_reg),
        .dec_rd         (dec_rd),
        .dec_wb_op      (dec_wb_op),
        .dec_jmp_op     (dec_jmp_op),
        .dec_mem_op     (dec_mem_op),
        .dec_fault      (dec_fault),
        .dec_ready      (dec_ready),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .jmp_resolved   (jmp_resolved),
        .mem_done       (mem_done),
        .busy_mask      (busy_mask),
        .inflight       (inflight),
        .halted         (halted),
        .dbg_state      (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit    m_busy[32];
    int    m_infl;
    int    m_mode;
    bit    m_fire;
    string phase = "reset";
    int    checks = 0;
    int    errors = 0;
    logic [W-1:0] exp_q[$];

    function automatic bit model_iv();
        bit hz = 1'b0;
        for (int i = 0; i < 32; i++) hz |= dec_active_reg[i] & m_busy[i];
        return (m_mode == M_RUN) && dec_valid && !dec_fault && !hz && (m_infl < MAXI)
               && !((dec_wb_op != 0) && (m_infl == MAXI));
    endfunction

    function automatic logic [W-1:0] model_out();
        logic [31:0] bm;
        bit iv;
        iv = model_iv();
        for (int i = 0; i < 32; i++) bm[i] = m_busy[i];
        return {iv, iv && issue_ready, (m_mode == M_HALT), 4'(m_infl), bm};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_infl = 0;
        m_mode = M_RUN;
        m_fire = 1'b0;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_update();
        bit fire;
        fire = model_iv() && issue_ready;
        if (wb_valid && wb_rd != 0 && m_busy[wb_rd]) begin
            m_busy[wb_rd] = 1'b0;
            m_infl--;
        end
        if (fire && dec_wb_op != 0 && dec_rd != 0) begin
            m_busy[dec_rd] = 1'b1;
            m_infl++;
        end
        case (m_mode)
            M_RUN: begin
                if (dec_valid && dec_fault) m_mode = M_HALT;
                else if (fire && dec_jmp_op != 0) m_mode = M_JWAIT;
                else if (fire && dec_mem_op != 0) m_mode = M_MWAIT;
            end
            M_JWAIT: if (jmp_resolved) m_mode = M_RUN;
            M_MWAIT: if (mem_done) m_mode = M_RUN;
            default: m_mode = M_HALT;
        endcase
        m_fire = fire;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        exp_q.push_back(model_out());
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    task automatic set_instr(input logic [31:0] mask, input logic [4:0] rd, input logic [1:0] wb,
                             input logic [1:0] jmp, input logic [1:0] mem, input logic flt);
        dec_valid      = 1'b1;
        dec_active_reg = mask;
        dec_rd         = rd;
        dec_wb_op      = wb;
        dec_jmp_op     = jmp;
        dec_mem_op     = mem;
        dec_fault      = flt;
    endtask

    task automatic clear_pulses();
        wb_valid     = 1'b0;
        jmp_resolved = 1'b0;
        mem_done     = 1'b0;
    endtask

    function automatic logic [31:0] rb(input int r);
        logic [31:0] m;
        m    = '0;
        m[r] = 1'b1;
        return m;
    endfunction

    task automatic gen_instr();
        int rs1, rs2, rd, r;
        rs1 = $urandom_range(0, 7);
        rs2 = $urandom_range(0, 7);
        rd  = $urandom_range(0, 9);
        r   = $urandom_range(0, 99);
        set_instr(rb(rs1) | rb(rs2) | rb(rd), 5'(rd), 2'($urandom_range(0, 2)),
                  (r < 10) ? 2'($urandom_range(1, 2)) : 2'd0,
                  (r >= 10 && r < 25) ? 2'($urandom_range(1, 2)) : 2'd0,
                  ($urandom_range(0, 99) < 2));
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e, g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {issue_valid, dec_ready, halted, inflight, busy_mask};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s @%0t: got iv=%b rdy=%b halt=%b infl=%0d busy=%h, expected iv=%b rdy=%b halt=%b infl=%0d busy=%h",
                         phase, $time, g[38], g[37], g[36], g[35:32], g[31:0],
                         e[38], e[37], e[36], e[35:32], e[31:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int halt_cnt;
        model_reset();
        do_reset();
        phase = "reset_state";
        step();

        // RAW hazard on x5, released the cycle after its writeback
        phase = "raw";
        issue_ready = 1'b1;
        set_instr(rb(5) | rb(1), 5'd5, 2'd1, 2'd0, 2'd0, 1'b0);
        step();
        set_instr(rb(6) | rb(5) | rb(1), 5'd6, 2'd1, 2'd0, 2'd0, 1'b0);
        repeat (3) step();
        wb_valid = 1'b1; wb_rd = 5'd5;
        step();
        clear_pulses();
        step();
        dec_valid = 1'b0;
        step();

        // inflight limit
        phase = "inflight_limit";
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_instr(rb(10 + i), 5'(10 + i), 2'd1, 2'd0, 2'd0, 1'b0);
            step();
        end
        set_instr(rb(14), 5'd14, 2'd1, 2'd0, 2'd0, 1'b0);
        repeat (2) step();
        wb_valid = 1'b1; wb_rd = 5'd10;
        step();
        clear_pulses();
        step();
        dec_valid = 1'b0;
        step();

        // jump serialisation
        phase = "jwait";
        do_reset();
        set_instr(rb(1), 5'd1, 2'd2, 2'd1, 2'd0, 1'b0);
        step();
        set_instr(rb(2) | rb(3), 5'd3, 2'd1, 2'd0, 2'd0, 1'b0);
        mem_done = 1'b1;
        repeat (3) step();
        clear_pulses();
        jmp_resolved = 1'b1;
        step();
        clear_pulses();
        step();
        dec_valid = 1'b0;
        step();

        // load serialisation
        phase = "mwait";
        do_reset();
        set_instr(rb(7) | rb(2), 5'd7, 2'd1, 2'd0, 2'd1, 1'b0);
        step();
        set_instr(rb(8) | rb(4), 5'd8, 2'd1, 2'd0, 2'd0, 1'b0);
        jmp_resolved = 1'b1;
        repeat (2) step();
        clear_pulses();
        mem_done = 1'b1; wb_valid = 1'b1; wb_rd = 5'd7;
        step();
        clear_pulses();
        step();
        dec_valid = 1'b0;
        step();

        // fault halts even with busy registers; writeback still clears; reset recovers
        phase = "fault";
        set_instr(rb(8) | rb(9), 5'd9, 2'd1, 2'd0, 2'd0, 1'b1);
        step();
        repeat (2) step();
        dec_fault = 1'b0;
        step();
        wb_valid = 1'b1; wb_rd = 5'd8;
        step();
        clear_pulses();
        step();
        do_reset();
        dec_valid = 1'b0;
        step();

        // writeback corner cases
        phase = "wb_corner";
        wb_valid = 1'b1; wb_rd = 5'd0;
        step();
        wb_rd = 5'd17;
        step();
        clear_pulses();
        set_instr(rb(9), 5'd9, 2'd1, 2'd0, 2'd0, 1'b0);
        step();
        set_instr(rb(12) | rb(2), 5'd12, 2'd1, 2'd0, 2'd0, 1'b0);
        wb_valid = 1'b1; wb_rd = 5'd9;
        step();
        clear_pulses();
        set_instr(rb(3), 5'd0, 2'd1, 2'd0, 2'd0, 1'b0);
        step();
        dec_valid = 1'b0;
        step();

        // randomized traffic
        phase = "random";
        do_reset();
        halt_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            clear_pulses();
            if (m_fire) dec_valid = 1'b0;
            if (!dec_valid && $urandom_range(0, 99) < 80) gen_instr();
            issue_ready = ($urandom_range(0, 99) < 75);
            if ($urandom_range(0, 99) < 35) begin
                int s;
                wb_valid = 1'b1;
                wb_rd    = 5'($urandom_range(0, 31));
                s        = $urandom_range(0, 31);
                if ($urandom_range(0, 99) < 70)
                    for (int k = 0; k < 32; k++)
                        if (m_busy[(s + k) % 32]) wb_rd = 5'((s + k) % 32);
            end
            jmp_resolved = ($urandom_range(0, 99) < 30);
            mem_done     = ($urandom_range(0, 99) < 30);
            halt_cnt = (m_mode == M_HALT) ? halt_cnt + 1 : 0;
            if (halt_cnt > 8 || $urandom_range(0, 299) == 0) begin
                do_reset();
                halt_cnt = 0;
            end
            step();
        end

        clear_pulses();
        dec_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
